cypher_packer: RTL and testbench

//   Builds the 16-bit cypher consumed by the cypher-check datapath. Accepts digits one at a

---
 rtl/cypher_packer.sv | 135 +++++++++++++
 tb/tb_cypher_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cypher_packer.sv
// cypher_packer: collects DIGITS nibble-wide digits over a valid/ready handshake,
// packs them little-endian (digit 0 in bits [3:0]), keeps a running digit sum,
// rejects out-of-range and (optionally) duplicate digits, then presents the
// finished cypher with valid/ack until the consumer takes it.
module cypher_packer #(
  parameter int DIGITS     = 4,
  parameter int MAX_DIGIT  = 9,
  parameter int REJECT_DUP = 1,
  parameter int SUM_W      = 8,
  parameter int CYPHER_W   = DIGITS * 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                start,
  input  logic                digit_valid,
  input  logic [3:0]          digit,
  output logic                digit_ready,
  output logic                err_range,
  output logic                err_dup,
  output logic                busy,
  output logic [CYPHER_W-1:0] cypher,
  output logic [SUM_W-1:0]    digit_sum,
  output logic                cypher_valid,
  input  logic                cypher_ack
);

  localparam int         IDX_W    = $clog2(DIGITS + 1);
  localparam logic [3:0] MAX_D    = 4'(MAX_DIGIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CYPHER_W-1:0] cypher_q, cypher_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                err_range_q, err_range_d;
  logic                err_dup_q, err_dup_d;
  logic                dup_hit;

  // Compare the offered digit against every digit already stored this cypher.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((IDX_W'(i) < idx_q) && (cypher_q[4*i +: 4] == digit)) begin
        dup_hit = 1'b1;
      end
    end
  end

  // Next-state logic: clear first, then per-state handling of start, digits and ack.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cypher_d    = cypher_q;
    sum_d       = sum_q;
    err_range_d = 1'b0;
    err_dup_d   = 1'b0;

    if (clear) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      cypher_d = '0;
      sum_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            idx_d    = '0;
            cypher_d = '0;
            sum_d    = '0;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          if (digit_valid) begin
            if (digit > MAX_D) begin
              err_range_d = 1'b1;
            end else if ((REJECT_DUP != 0) && dup_hit) begin
              err_dup_d = 1'b1;
            end else begin
              for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) cypher_d[4*i +: 4] = digit;
              end
              sum_d = sum_q + SUM_W'(digit);
              idx_d = idx_q + 1'b1;
              if (idx_q == LAST_IDX) state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (cypher_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cypher_q    <= '0;
      sum_q       <= '0;
      err_range_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      cypher_q    <= cypher_d;
      sum_q       <= sum_d;
      err_range_q <= err_range_d;
      err_dup_q   <= err_dup_d;
    end
  end

  assign digit_ready  = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign cypher_valid = (state_q == S_HOLD);
  assign err_range    = err_range_q;
  assign err_dup      = err_dup_q;
  assign cypher       = cypher_q;
  assign digit_sum    = sum_q;

endmodule

// File: tb/tb_cypher_packer.sv
// Directed bench for cypher_packer: table of full cyphers plus hand-written
// sequences for reset, clear, ignored start, handshake gaps and held ack.
module tb_cypher_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear, start, digit_valid, cypher_ack;
  logic [3:0]  digit;

  logic        a_ready, a_erange, a_edup, a_busy, a_valid;
  logic [15:0] a_cypher;
  logic [7:0]  a_sum;
  logic        b_ready, b_erange, b_edup, b_busy, b_valid;
  logic [15:0] b_cypher;
  logic [7:0]  b_sum;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  cypher_packer dut_a (
    .clock(clock), .reset_n(reset_n), .clear(clear), .start(start),
    .digit_valid(digit_valid), .digit(digit), .digit_ready(a_ready),
    .err_range(a_erange), .err_dup(a_edup), .busy(a_busy),
    .cypher(a_cypher), .digit_sum(a_sum), .cypher_valid(a_valid),
    .cypher_ack(cypher_ack)
  );

  cypher_packer #(.REJECT_DUP(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .clear(clear), .start(start),
    .digit_valid(digit_valid), .digit(digit), .digit_ready(b_ready),
    .err_range(b_erange), .err_dup(b_edup), .busy(b_busy),
    .cypher(b_cypher), .digit_sum(b_sum), .cypher_valid(b_valid),
    .cypher_ack(cypher_ack)
  );

  typedef struct {
    int          n;
    logic [3:0]  d [8];
    logic [7:0]  rmask;
    logic [7:0]  dmask;
    logic [15:0] cyp;
    logic [7:0]  sum;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full cypher on dut_a: start, digits back-to-back, hold, ignored start, ack.
  task automatic run_vec(input vec_t v, input int id);
    string tag;
    tag = $sformatf("v%0d", id);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 32'(a_busy), 32'd1);
    check({tag, "_ready"}, 32'(a_ready), 32'd1);
    for (int k = 0; k < v.n; k++) begin
      digit_valid = 1'b1;
      digit       = v.d[k];
      if (k == v.n - 1) check({tag, "_valid_early"}, 32'(a_valid), 32'd0);
      step();
      check($sformatf("%s_erange_%0d", tag, k), 32'(a_erange), 32'(v.rmask[k]));
      check($sformatf("%s_edup_%0d", tag, k), 32'(a_edup), 32'(v.dmask[k]));
    end
    digit_valid = 1'b0;
    check({tag, "_valid"}, 32'(a_valid), 32'd1);
    check({tag, "_cypher"}, 32'(a_cypher), 32'(v.cyp));
    check({tag, "_sum"}, 32'(a_sum), 32'(v.sum));
    check({tag, "_ready_hold"}, 32'(a_ready), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check({tag, "_valid_held"}, 32'(a_valid), 32'd1);
    check({tag, "_cypher_held"}, 32'(a_cypher), 32'(v.cyp));
    cypher_ack = 1'b1;
    step();
    cypher_ack = 1'b0;
    check({tag, "_valid_ack"}, 32'(a_valid), 32'd0);
    check({tag, "_busy_ack"}, 32'(a_busy), 32'd0);
    check({tag, "_cypher_kept"}, 32'(a_cypher), 32'(v.cyp));
    check({tag, "_sum_kept"}, 32'(a_sum), 32'(v.sum));
  endtask

  task automatic feed(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step();
    digit_valid = 1'b0;
  endtask

  initial begin
    vecs[0].n = 4; vecs[0].d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[0].rmask = 8'h00; vecs[0].dmask = 8'h00; vecs[0].cyp = 16'h4321; vecs[0].sum = 8'd10;
    vecs[1].n = 5; vecs[1].d = '{4'h5, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0};
    vecs[1].rmask = 8'h00; vecs[1].dmask = 8'h02; vecs[1].cyp = 16'h8765; vecs[1].sum = 8'd26;
    vecs[2].n = 6; vecs[2].d = '{4'hA, 4'hF, 4'h0, 4'h9, 4'h2, 4'h3, 4'h0, 4'h0};
    vecs[2].rmask = 8'h03; vecs[2].dmask = 8'h00; vecs[2].cyp = 16'h3290; vecs[2].sum = 8'd14;
    vecs[3].n = 4; vecs[3].d = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[3].rmask = 8'h00; vecs[3].dmask = 8'h00; vecs[3].cyp = 16'h6789; vecs[3].sum = 8'd30;

    reset_n = 1'b0; clear = 1'b0; start = 1'b0; digit_valid = 1'b0;
    digit = 4'h0; cypher_ack = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_cypher", 32'(a_cypher), 32'd0);
    check("rst_sum", 32'(a_sum), 32'd0);

    // Digits offered in IDLE are ignored without an error pulse.
    feed(4'hF);
    check("idle_digit_erange", 32'(a_erange), 32'd0);
    check("idle_digit_busy", 32'(a_busy), 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Duplicates accepted when REJECT_DUP=0.
    start = 1'b1;
    step();
    start = 1'b0;
    feed(4'h5);
    feed(4'h5);
    check("nodup_edup", 32'(b_edup), 32'd0);
    feed(4'h6);
    feed(4'h7);
    check("nodup_valid", 32'(b_valid), 32'd1);
    check("nodup_cypher", 32'(b_cypher), 32'h7655);
    check("nodup_sum", 32'(b_sum), 32'd23);

    // clear mid-load (dut_a has 5,6,7 stored) returns to IDLE with data wiped.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_busy", 32'(a_busy), 32'd0);
    check("clr_ready", 32'(a_ready), 32'd0);
    check("clr_cypher", 32'(a_cypher), 32'd0);
    check("clr_sum", 32'(a_sum), 32'd0);
    check("clr_b_valid", 32'(b_valid), 32'd0);

    // clear after two digits, then clear together with start.
    start = 1'b1;
    step();
    start = 1'b0;
    feed(4'h1);
    feed(4'h2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr2_busy", 32'(a_busy), 32'd0);
    check("clr2_cypher", 32'(a_cypher), 32'd0);
    check("clr2_ready", 32'(a_ready), 32'd0);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    check("clr_start_busy", 32'(a_busy), 32'd0);

    // start during LOAD does not restart the cypher.
    start = 1'b1;
    step();
    feed(4'h1);
    start = 1'b1;
    feed(4'h2);
    start = 1'b0;
    feed(4'h3);
    feed(4'h4);
    check("load_start_valid", 32'(a_valid), 32'd1);
    check("load_start_cypher", 32'(a_cypher), 32'h4321);
    cypher_ack = 1'b1;
    step();
    cypher_ack = 1'b0;

    // Random gaps in digit_valid give the same cypher.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      int gap;
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) begin
        digit = 4'($urandom_range(0, 15));
        step();
      end
      feed(4'(k));
    end
    check("gap_valid", 32'(a_valid), 32'd1);
    check("gap_cypher", 32'(a_cypher), 32'h4321);
    check("gap_sum", 32'(a_sum), 32'd10);
    cypher_ack = 1'b1;
    step();

    // Ack held high across start: HOLD is still entered.
    start = 1'b1;
    step();
    start = 1'b0;
    feed(4'h1);
    feed(4'h2);
    feed(4'h3);
    feed(4'h4);
    check("ackhigh_valid", 32'(a_valid), 32'd1);
    check("ackhigh_cypher", 32'(a_cypher), 32'h4321);
    step();
    check("ackhigh_idle", 32'(a_busy), 32'd0);
    cypher_ack = 1'b0;

    // Asynchronous reset mid-load clears everything immediately.
    start = 1'b1;
    step();
    start = 1'b0;
    feed(4'h7);
    feed(4'h8);
    reset_n = 1'b0;
    #1;
    check("arst_cypher", 32'(a_cypher), 32'd0);
    check("arst_sum", 32'(a_sum), 32'd0);
    check("arst_busy", 32'(a_busy), 32'd0);
    check("arst_ready", 32'(a_ready), 32'd0);
    check("arst_valid", 32'(a_valid), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("arst_rel_busy", 32'(a_busy), 32'd0);
    check("arst_rel_ready", 32'(a_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
